apb_gpio_bridge: RTL
====================

// Module: apb_gpio_bridge
// PURPOSE
//  APB3 slave front-end directly upstream of the GPIO port block.
//  Turns APB setup/access phases into the GPIO local bus (BUSW, BUSWDATA, REGSEL) and returns BUSRDATA as PRDATA.
//  Handles the GPIO's registered read latency with a small FSM and inserts one wait state per legal transfer.
// PARAMETERS
//  ADDR_W     8      APB address width
//  DATA_W     32     APB data width, must be >= GPIO_W
//  GPIO_W     8      GPIO local-bus width
//  BASE_ADDR  8'h00  block base; decode window is 16 bytes (PADDR[ADDR_W-1:4])
// PORTS
//  clk       in   1       system clock, all logic on rising edge
//  rst       in   1       synchronous reset, active-high
//  PSEL      in   1       APB select
//  PENABLE   in   1       APB access phase
//  PWRITE    in   1       1 = write
//  PADDR     in   ADDR_W  byte address
//  PWDATA    in   DATA_W  write data; only [GPIO_W-1:0] used
//  PRDATA    out  DATA_W  read data, zero-extended BUSRDATA
//  PREADY    out  1       transfer completes this cycle
//  PSLVERR   out  1       error response (only with APB_GPIO_SLVERR_EN)
//  BUSW      out  1       GPIO write strobe, one cycle wide
//  BUSWDATA  out  GPIO_W  GPIO write data
//  REGSEL    out  2       GPIO register select: 00 = PIN, 10 = DIR, 11 = PORT
//  BUSRDATA  in   GPIO_W  GPIO read data; valid one edge after REGSEL is driven with BUSW = 0
// BEHAVIOUR
//  Register map (offset = PADDR[3:0]):
//   0x0 PIN (RO), 0x8 DIR (RW), 0xC PORT (RW).
//   Illegal accesses:
//    - 0x4 (any access)
//    - any PADDR[1:0] != 0
//    - write to 0x0
//    - base mismatch
//  Reset values (rst = 1 at an edge):
//   - state = IDLE
//   - PREADY = 0, PSLVERR = 0, PRDATA = 0
//   - BUSW = 0, BUSWDATA = 0, REGSEL = 2'b00
//  BUSW is additionally gated by !rst, so no GPIO write lands in any cycle where rst is high.
//  FSM states:
//   IDLE:
//    - On PSEL & !PENABLE, latch PWRITE, PADDR and PWDATA[GPIO_W-1:0] and decode.
//    - Legal write -> WR. Legal read -> RD. Illegal -> RESP with err = 1.
//   WR (1 cycle):
//    - BUSW = 1, REGSEL = decoded code, BUSWDATA = latched data.
//    - GPIO captures on the closing edge. -> RESP.
//   RD (1 cycle):
//    - BUSW = 0, REGSEL = decoded code. GPIO loads BUSRDATA on the closing edge. -> RESP.
//   RESP (1 cycle):
//    - PREADY = 1; REGSEL held; BUSW = 0.
//    - PRDATA = {0, BUSRDATA} for legal reads, else 0. -> IDLE.
//  Latency:
//   - Legal transfer: setup, WR/RD, RESP = 1 wait state (PREADY high in the 2nd access cycle).
//   - Illegal transfer: PREADY high in the 1st access cycle.
//  Back-to-back: a setup phase in the cycle after RESP is accepted by IDLE. Throughput is 3 cycles per legal transfer.
//  Protocol violations:
//   - PENABLE seen in IDLE without a preceding setup: ignored.
//   - PSEL dropped after setup: transfer still completes internally (a write still lands), then IDLE.
//  Outside RESP: PREADY = 0 and PRDATA = 0. In IDLE: REGSEL = 00 and BUSW = 0.
//  Reset mid-transfer: the transfer is abandoned and no completion is signalled.
// CONFIGURATION
//  APB_GPIO_SLVERR_EN
//   - Defined: PSLVERR = err, asserted only in RESP.
//   - Undefined: PSLVERR tied 0. Illegal writes are still dropped (no BUSW) and illegal reads still return 0.
// STRUCTURE
//  apb_gpio_pkg:
//   - state enum {IDLE, WR, RD, RESP}
//   - offset constants OFS_PIN, OFS_DIR, OFS_PORT
//   - REGSEL codes SEL_PIN, SEL_DIR, SEL_PORT
//  Sub-module apb_gpio_decode (combinational): inputs PADDR, PWRITE; outputs {legal, regsel}.
//  The top level holds the FSM and the data latches.
// TESTING
//  1. Write PADDR = 0x08, PWDATA = 0xA5:
//     BUSW = 1 for exactly 1 cycle with REGSEL = 10, BUSWDATA = 0xA5; PREADY on the 2nd access cycle; PSLVERR = 0.
//  2. After test 1, read 0x08: REGSEL = 10 during RD/RESP; PRDATA = 0x000000A5 with PREADY.
//  3. Read 0x00 with BUSRDATA driven to 0x3C by the GPIO model: PRDATA = 0x0000003C, REGSEL = 00.
//  4. Write 0x00 (or 0x04): no BUSW pulse; PREADY on the 1st access cycle.
//     PSLVERR = 1 with APB_GPIO_SLVERR_EN defined, 0 without it.
//  5. Back-to-back write 0x0C = 0xFF then read 0x0C with no idle cycle:
//     both complete at 3-cycle spacing; read returns 0xFF.
//  6. Assert rst during the WR cycle: BUSW = 0 in that cycle, state returns to IDLE, no PREADY.
//     The next transfer behaves normally.

Source files
------------

// File: rtl/apb_gpio_pkg.sv
// Shared types and constants for the APB-to-GPIO bridge: FSM states, register
// offsets within the 16-byte window, and GPIO REGSEL codes.
package apb_gpio_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [3:0] OFS_PIN  = 4'h0;
    localparam logic [3:0] OFS_DIR  = 4'h8;
    localparam logic [3:0] OFS_PORT = 4'hC;

    localparam logic [1:0] SEL_PIN  = 2'b00;
    localparam logic [1:0] SEL_DIR  = 2'b10;
    localparam logic [1:0] SEL_PORT = 2'b11;

endpackage

// File: rtl/apb_gpio_decode.sv
// Combinational address decode: maps an APB address/direction onto a GPIO
// register select and flags whether the access is legal.
module apb_gpio_decode
    import apb_gpio_pkg::*;
#(
    parameter int unsigned           ADDR_W    = 8,
    parameter logic [ADDR_W-1:0]     BASE_ADDR = '0
) (
    input  logic [ADDR_W-1:0] PADDR,
    input  logic              PWRITE,
    output logic              legal,
    output logic [1:0]        regsel
);

    logic base_hit;

    always_comb begin
        base_hit = (PADDR[ADDR_W-1:4] == BASE_ADDR[ADDR_W-1:4]);
        legal    = 1'b0;
        regsel   = SEL_PIN;
        case (PADDR[3:0])
            OFS_PIN: begin
                regsel = SEL_PIN;
                legal  = base_hit & ~PWRITE;
            end
            OFS_DIR: begin
                regsel = SEL_DIR;
                legal  = base_hit;
            end
            OFS_PORT: begin
                regsel = SEL_PORT;
                legal  = base_hit;
            end
            default: begin
                regsel = SEL_PIN;
                legal  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/apb_gpio_bridge.sv
// APB3 slave front-end for the GPIO port block: one wait state per legal
// transfer, immediate response for illegal ones. Optional error response via
// `APB_GPIO_SLVERR_EN.
module apb_gpio_bridge
    import apb_gpio_pkg::*;
#(
    parameter int unsigned           ADDR_W    = 8,
    parameter int unsigned           DATA_W    = 32,
    parameter int unsigned           GPIO_W    = 8,
    parameter logic [ADDR_W-1:0]     BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic              BUSW,
    output logic [GPIO_W-1:0] BUSWDATA,
    output logic [1:0]        REGSEL,
    input  logic [GPIO_W-1:0] BUSRDATA
);

    state_t            state;
    state_t            state_next;
    logic              dec_legal;
    logic [1:0]        dec_regsel;
    logic              setup;
    logic              write_q;
    logic              err_q;
    logic [1:0]        sel_q;
    logic [GPIO_W-1:0] wdata_q;
    logic              unused_ok;

    apb_gpio_decode #(
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE_ADDR)
    ) u_decode (
        .PADDR  (PADDR),
        .PWRITE (PWRITE),
        .legal  (dec_legal),
        .regsel (dec_regsel)
    );

    assign setup = PSEL & ~PENABLE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            write_q <= 1'b0;
            err_q   <= 1'b0;
            sel_q   <= SEL_PIN;
            wdata_q <= '0;
        end else if (state == IDLE && setup) begin
            write_q <= PWRITE;
            err_q   <= ~dec_legal;
            sel_q   <= dec_regsel;
            wdata_q <= PWDATA[GPIO_W-1:0];
        end
    end

    always_comb begin
        state_next = state;
        PREADY     = 1'b0;
        PRDATA     = '0;
        BUSW       = 1'b0;
        REGSEL     = sel_q;
        case (state)
            IDLE: begin
                REGSEL = SEL_PIN;
                if (setup) begin
                    if (!dec_legal) state_next = RESP;
                    else if (PWRITE) state_next = WR;
                    else             state_next = RD;
                end
            end
            WR: begin
                // gated by rst so an abandoned transfer never reaches the GPIO
                BUSW       = ~rst;
                state_next = RESP;
            end
            RD: begin
                state_next = RESP;
            end
            RESP: begin
                PREADY = 1'b1;
                if (!err_q && !write_q) PRDATA = DATA_W'(BUSRDATA);
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign BUSWDATA  = wdata_q;
    assign unused_ok = &{1'b0, PWDATA};

`ifdef APB_GPIO_SLVERR_EN
    assign PSLVERR = (state == RESP) & err_q;
`else
    assign PSLVERR = 1'b0;
`endif

endmodule
